smp_ckt_seq: RTL and testbench

- Registered, parametrised successor to the 4-bit combinational sample circuit.
- Takes G_WIDTH-bit samples under a valid/ready handshake and computes two flags per sample, QX and QY, selected by G_MODE; results appear one cycle after acceptance.
- A run-detector FSM pulses RUN_HIT on the output sample that completes G_RUN consecutive QX=1 samples.
- A saturating counter accumulates hits.
- Sits between a sample source (switches or stimulus generator) and a downstream consumer or display.

---
 rtl/smp_ckt_pkg.sv | 25 ++
 rtl/smp_ckt_flags.sv | 33 +++
 rtl/smp_ckt_seq.sv | 147 ++++++++++++++
 tb/tb_smp_ckt_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smp_ckt_pkg.sv
// Shared types and helpers for the registered sample circuit.
package smp_ckt_pkg;

  localparam int unsigned MODE_PAR_ONES  = 0;
  localparam int unsigned MODE_MAJ_ZEROS = 1;

  // Widest sample popcount() accepts; narrower samples are zero-extended.
  localparam int unsigned POP_MAX_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HIT
  } run_state_t;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/smp_ckt_flags.sv
// Combinational flag pair: parity/all-ones (mode 0) or majority/all-zeros (mode 1).
module smp_ckt_flags
  import smp_ckt_pkg::*;
#(
  parameter int unsigned G_WIDTH = 4,
  parameter int unsigned G_MODE  = MODE_PAR_ONES
) (
  input  logic [G_WIDTH-1:0] d,
  output logic               qx,
  output logic               qy
);

  if (G_WIDTH > POP_MAX_W) begin : g_bad_width
    $error("smp_ckt_flags: G_WIDTH exceeds POP_MAX_W");
  end

  if (G_MODE == MODE_PAR_ONES) begin : g_par_ones
    assign qx = ^d;
    assign qy = &d;
  end else begin : g_maj_zeros
    logic [POP_MAX_W-1:0] d_ext;

    always_comb begin
      d_ext = '0;
      d_ext[G_WIDTH-1:0] = d;
    end

    // Strict majority: an exact half does not count.
    assign qx = popcount(d_ext) > (G_WIDTH / 2);
    assign qy = (d == '0);
  end

endmodule

// File: rtl/smp_ckt_seq.sv
// Registered sample circuit with valid/ready handshake, run detector and saturating hit counter.
// Optional synchronous clear port enabled by defining SMP_CKT_SEQ_CLR_EN.
module smp_ckt_seq
  import smp_ckt_pkg::*;
#(
  parameter int unsigned G_WIDTH = 4,
  parameter int unsigned G_MODE  = MODE_PAR_ONES,
  parameter int unsigned G_RUN   = 3,
  parameter int unsigned G_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SMP_CKT_SEQ_CLR_EN
  input  logic               clr,
`endif
  input  logic               d_vld,
  output logic               d_rdy,
  input  logic [G_WIDTH-1:0] d,
  output logic               q_vld,
  input  logic               q_rdy,
  output logic               qx,
  output logic               qy,
  output logic               run_hit,
  output logic [G_CNT_W-1:0] hit_cnt
);

  localparam int unsigned RunW = $clog2(G_RUN + 1);

  if (G_WIDTH < 2) begin : g_bad_width
    $error("smp_ckt_seq: G_WIDTH must be >= 2");
  end
  if (G_MODE > MODE_MAJ_ZEROS) begin : g_bad_mode
    $error("smp_ckt_seq: G_MODE must be 0 or 1");
  end
  if (G_RUN < 1) begin : g_bad_run
    $error("smp_ckt_seq: G_RUN must be >= 1");
  end

  logic               clr_int;
  logic               accept;
  logic               fx;
  logic               fy;
  logic               hit;
  logic [RunW-1:0]    run_inc;
  run_state_t         state_q, state_d;
  logic [RunW-1:0]    run_q, run_d;
  logic [G_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic               q_vld_q, qx_q, qy_q;

`ifdef SMP_CKT_SEQ_CLR_EN
  assign clr_int = clr;
`else
  assign clr_int = 1'b0;
`endif

  smp_ckt_flags #(
    .G_WIDTH(G_WIDTH),
    .G_MODE (G_MODE)
  ) u_flags (
    .d (d),
    .qx(fx),
    .qy(fy)
  );

  assign d_rdy   = !q_vld_q || q_rdy;
  assign accept  = d_vld && d_rdy;
  assign run_inc = run_q + RunW'(1);

  // S_HIT only marks the held output; the next accept restarts as from S_IDLE.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    hit_cnt_d = hit_cnt_q;
    hit       = 1'b0;
    if (accept) begin
      case (state_q)
        S_RUN: begin
          if (fx) begin
            run_d = run_inc;
            if (run_inc == RunW'(G_RUN)) begin
              state_d = S_HIT;
              hit     = 1'b1;
            end
          end else begin
            run_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: begin
          if (fx) begin
            run_d = RunW'(1);
            if (G_RUN == 1) begin
              state_d = S_HIT;
              hit     = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            run_d   = '0;
            state_d = S_IDLE;
          end
        end
      endcase
    end
    if (hit && (hit_cnt_q != {G_CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + G_CNT_W'(1);
    end
    if (clr_int) begin
      state_d   = S_IDLE;
      run_d     = '0;
      hit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld_q <= 1'b0;
      qx_q    <= 1'b0;
      qy_q    <= 1'b0;
    end else if (accept) begin
      q_vld_q <= 1'b1;
      qx_q    <= fx;
      qy_q    <= fy;
    end else if (q_rdy) begin
      q_vld_q <= 1'b0;
    end
  end

  assign q_vld   = q_vld_q;
  assign qx      = qx_q;
  assign qy      = qy_q;
  assign run_hit = q_vld_q && (state_q == S_HIT);
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_smp_ckt_seq.sv
// Bench for smp_ckt_seq: mode 0 and mode 1 instances share stimulus, checked against a model.
module tb_smp_ckt_seq;

  localparam int unsigned W    = 4;
  localparam int unsigned RUN  = 3;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic            d_vld;
  logic [W-1:0]    d;
  logic            q_rdy;
  logic [1:0]      d_rdy;
  logic [1:0]      q_vld;
  logic [1:0]      qx;
  logic [1:0]      qy;
  logic [1:0]      run_hit;
  logic [1:0][CW-1:0] hit_cnt;
`ifdef SMP_CKT_SEQ_CLR_EN
  logic            clr = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  smp_ckt_seq #(.G_WIDTH(W), .G_MODE(0), .G_RUN(RUN), .G_CNT_W(CW)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef SMP_CKT_SEQ_CLR_EN
    .clr    (clr),
`endif
    .d_vld  (d_vld),
    .d_rdy  (d_rdy[0]),
    .d      (d),
    .q_vld  (q_vld[0]),
    .q_rdy  (q_rdy),
    .qx     (qx[0]),
    .qy     (qy[0]),
    .run_hit(run_hit[0]),
    .hit_cnt(hit_cnt[0])
  );

  smp_ckt_seq #(.G_WIDTH(W), .G_MODE(1), .G_RUN(RUN), .G_CNT_W(CW)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef SMP_CKT_SEQ_CLR_EN
    .clr    (clr),
`endif
    .d_vld  (d_vld),
    .d_rdy  (d_rdy[1]),
    .d      (d),
    .q_vld  (q_vld[1]),
    .q_rdy  (q_rdy),
    .qx     (qx[1]),
    .qy     (qy[1]),
    .run_hit(run_hit[1]),
    .hit_cnt(hit_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference flags straight from the rules.
  function automatic bit ref_x(input int mode, input logic [W-1:0] v);
    if (mode == 0) return ($countones(v) % 2) == 1;
    return $countones(v) > (W / 2);
  endfunction

  function automatic bit ref_y(input int mode, input logic [W-1:0] v);
    if (mode == 0) return v == {W{1'b1}};
    return v == '0;
  endfunction

  // Model: last accepted sample, per-mode streak of QX=1 samples, hit flag, saturating count.
  bit           m_qvld = 1'b0;
  logic [W-1:0] m_d = '0;
  bit           m_hit [2];
  int           m_streak [2];
  int           m_cnt [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_qvld = 1'b0;
      m_d    = '0;
      for (int m = 0; m < 2; m++) begin
        m_hit[m] = 1'b0;
        m_streak[m] = 0;
        m_cnt[m] = 0;
      end
    end else if (d_vld && (!m_qvld || q_rdy)) begin
      m_qvld = 1'b1;
      m_d    = d;
      for (int m = 0; m < 2; m++) begin
        m_hit[m] = 1'b0;
        if (ref_x(m, d)) begin
          m_streak[m]++;
          if (m_streak[m] == RUN) begin
            m_hit[m] = 1'b1;
            m_streak[m] = 0;
            if (m_cnt[m] < CMAX) m_cnt[m]++;
          end
        end else begin
          m_streak[m] = 0;
        end
      end
    end else if (q_rdy) begin
      m_qvld = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d_rdy[%0d]", m), 32'(d_rdy[m]), 32'(!m_qvld || q_rdy));
      chk($sformatf("q_vld[%0d]", m), 32'(q_vld[m]), 32'(m_qvld));
      chk($sformatf("hit_cnt[%0d]", m), 32'(hit_cnt[m]), 32'(m_cnt[m]));
      if (m_qvld) begin
        chk($sformatf("qx[%0d]", m), 32'(qx[m]), 32'(ref_x(m, m_d)));
        chk($sformatf("qy[%0d]", m), 32'(qy[m]), 32'(ref_y(m, m_d)));
        chk($sformatf("run_hit[%0d]", m), 32'(run_hit[m]), 32'(m_hit[m]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that consumed these inputs.
  task automatic step(input bit vld, input logic [W-1:0] v, input bit rdy);
    d_vld = vld;
    d     = v;
    q_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    d_vld = 1'b0;
    d     = '0;
    q_rdy = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset q_vld", 32'(q_vld), 32'(0));
    chk("reset hit_cnt0", 32'(hit_cnt[0]), 32'(0));
    chk("reset d_rdy", 32'(d_rdy), 32'(3));
    rst_n = 1'b1;

    // Back-to-back exhaustive sweep with literal pins.
    for (int v = 0; v < 16; v++) begin
      step(1'b1, 4'(v), 1'b1);
      chk("sweep no bubble", 32'(q_vld), 32'(3));
      if (v == 7) begin
        chk("m0 d=7 qx", 32'(qx[0]), 32'(1));
        chk("m0 d=7 qy", 32'(qy[0]), 32'(0));
        chk("m1 d=7 qx", 32'(qx[1]), 32'(1));
        chk("m1 d=7 qy", 32'(qy[1]), 32'(0));
      end
      if (v == 15) begin
        chk("m0 d=15 qx", 32'(qx[0]), 32'(0));
        chk("m0 d=15 qy", 32'(qy[0]), 32'(1));
      end
      if (v == 3) chk("m1 d=3 qx", 32'(qx[1]), 32'(0));
      if (v == 0) begin
        chk("m1 d=0 qx", 32'(qx[1]), 32'(0));
        chk("m1 d=0 qy", 32'(qy[1]), 32'(1));
      end
    end

    // Run detection in mode 0.
    step(1'b1, 4'd1, 1'b1);
    chk("run1 hit", 32'(run_hit[0]), 32'(0));
    step(1'b1, 4'd2, 1'b1);
    chk("run2 hit", 32'(run_hit[0]), 32'(0));
    step(1'b1, 4'd4, 1'b1);
    chk("run3 hit", 32'(run_hit[0]), 32'(1));
    chk("run3 cnt", 32'(hit_cnt[0]), 32'(1));
    step(1'b1, 4'd7, 1'b1);
    chk("run4 hit", 32'(run_hit[0]), 32'(0));
    step(1'b1, 4'd3, 1'b1);
    step(1'b1, 4'd1, 1'b1);
    step(1'b1, 4'd1, 1'b1);
    step(1'b1, 4'd1, 1'b1);
    chk("second hit", 32'(run_hit[0]), 32'(1));
    chk("second cnt", 32'(hit_cnt[0]), 32'(2));

    // Saturation: three more hits.
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 4'd1, 1'b1);
      if (i == 3) chk("sat cnt3", 32'(hit_cnt[0]), 32'(3));
    end
    chk("sat last hit", 32'(run_hit[0]), 32'(1));
    chk("sat hold", 32'(hit_cnt[0]), 32'(3));

    // Backpressure.
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd7, 1'b0);
    chk("bp d_rdy", 32'(d_rdy[0]), 32'(0));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd9, 1'b0);
      chk("bp hold qx", 32'(qx[0]), 32'(1));
      chk("bp hold vld", 32'(q_vld[0]), 32'(1));
    end
    step(1'b1, 4'd9, 1'b1);
    chk("bp replaced qx", 32'(qx[0]), 32'(0));
    step(1'b0, 4'd0, 1'b1);
    chk("bp no dup", 32'(q_vld[0]), 32'(0));

    // Reset while in a run.
    step(1'b1, 4'd1, 1'b1);
    rst_n = 1'b0;
    d_vld = 1'b0;
    #1;
    chk("rst q_vld", 32'(q_vld), 32'(0));
    chk("rst qx", 32'(qx), 32'(0));
    chk("rst run_hit", 32'(run_hit), 32'(0));
    chk("rst cnt", 32'(hit_cnt[0]), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'd1, 1'b1);
    step(1'b1, 4'd2, 1'b1);
    chk("post rst no hit", 32'(run_hit[0]), 32'(0));
    step(1'b1, 4'd4, 1'b1);
    chk("post rst hit", 32'(run_hit[0]), 32'(1));
    chk("post rst cnt", 32'(hit_cnt[0]), 32'(1));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    end
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
